// File: rtl/sd_cmd_resp_rx.sv
`default_nettype none
// sd_cmd_resp_rx -- bit-serial SD CMD-line response receiver for 48/136-bit frames
// with CRC7, framing and Ncr-timeout checks.  Rev 1.0
module sd_cmd_resp_rx #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bit_en,
   input  logic         cmd_in,
   input  logic         start,
   input  logic         long_resp,
   input  logic         skip_crc,
   output logic         busy,
   output logic         done,
   output logic [5:0]   resp_index,
   output logic [31:0]  resp_arg,
   output logic [119:0] resp_long,
   output logic         crc_err,
   output logic         frame_err,
   output logic         timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_HDR  = 3'd2,
      S_BODY = 3'd3,
      S_CRC  = 3'd4,
      S_END  = 3'd5
   } state_t;

   state_t          state;
   logic            long_q;
   logic            skip_q;
   logic [TW-1:0]   tmo_cnt;
   logic [6:0]      bit_cnt;
   logic            tbit;
   logic [5:0]      idx;
   logic [119:0]    body;
   logic [6:0]      crc;
   logic [6:0]      rx_crc;

   // Galois CRC7 step, polynomial x^7 + x^3 + 1
   function automatic logic [6:0] crc7_step(input logic [6:0] sr, input logic d);
      logic fb;
      fb = sr[6] ^ d;
      return {sr[5:4], sr[3], sr[2] ^ fb, sr[1:0], fb};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         long_q     <= 1'b0;
         skip_q     <= 1'b0;
         tmo_cnt    <= '0;
         bit_cnt    <= '0;
         tbit       <= 1'b0;
         idx        <= '0;
         body       <= '0;
         crc        <= '0;
         rx_crc     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         resp_index <= '0;
         resp_arg   <= '0;
         resp_long  <= '0;
         crc_err    <= 1'b0;
         frame_err  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  long_q     <= long_resp;
                  skip_q     <= skip_crc;
                  tmo_cnt    <= '0;
                  body       <= '0;
                  resp_index <= '0;
                  resp_arg   <= '0;
                  resp_long  <= '0;
                  crc_err    <= 1'b0;
                  frame_err  <= 1'b0;
                  timeout    <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bit_en) begin
                  if (!cmd_in) begin
                     // Start bit is 0, so clearing the CRC is the same as shifting it in
                     crc     <= '0;
                     bit_cnt <= '0;
                     state   <= S_HDR;
                  end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                     timeout <= 1'b1;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
               end
            end
            S_HDR: begin
               if (bit_en) begin
                  if (bit_cnt == 7'd0) tbit <= cmd_in;
                  else                 idx  <= {idx[4:0], cmd_in};
                  if (!long_q) crc <= crc7_step(crc, cmd_in);
                  if (bit_cnt == 7'd6) begin
                     bit_cnt <= '0;
                     state   <= S_BODY;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
            end
            S_BODY: begin
               if (bit_en) begin
                  body <= {body[118:0], cmd_in};
                  crc  <= crc7_step(crc, cmd_in);
                  if (bit_cnt == (long_q ? 7'd119 : 7'd31)) begin
                     bit_cnt <= '0;
                     state   <= S_CRC;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
            end
            S_CRC: begin
               if (bit_en) begin
                  rx_crc <= {rx_crc[5:0], cmd_in};
                  if (bit_cnt == 7'd6) begin
                     bit_cnt <= '0;
                     state   <= S_END;
                  end else begin
                     bit_cnt <= bit_cnt + 7'd1;
                  end
               end
            end
            S_END: begin
               if (bit_en) begin
                  frame_err  <= tbit | ~cmd_in;
                  crc_err    <= (crc != rx_crc) && !skip_q;
                  resp_index <= idx;
                  resp_arg   <= long_q ? 32'd0 : body[31:0];
                  resp_long  <= long_q ? body : 120'd0;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_resp_rx.sv
`default_nettype none
// tb_sd_cmd_resp_rx -- randomized self-checking bench with a polynomial-division CRC7 model.
// Rev 1.0
module tb_sd_cmd_resp_rx;
   localparam int TIMEOUT = 64;

   logic         clk = 1'b0;
   logic         reset, bit_en, cmd_in, start, long_resp, skip_crc;
   logic         busy, done, crc_err, frame_err, timeout;
   logic [5:0]   resp_index;
   logic [31:0]  resp_arg;
   logic [119:0] resp_long;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit noise_start = 1'b0;

   sd_cmd_resp_rx #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .bit_en(bit_en), .cmd_in(cmd_in), .start(start),
      .long_resp(long_resp), .skip_crc(skip_crc), .busy(busy), .done(done),
      .resp_index(resp_index), .resp_arg(resp_arg), .resp_long(resp_long),
      .crc_err(crc_err), .frame_err(frame_err), .timeout(timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (done) done_cnt++;

   // Remainder of M(x)*x^7 modulo x^7+x^3+1 over frame bits hi..lo (MSB first)
   function automatic logic [6:0] crc7_model(input logic [135:0] m, input int hi, input int lo);
      logic [7:0] rem = 8'd0;
      for (int i = hi; i >= lo; i--) begin
         rem = {rem[6:0], m[i]};
         if (rem[7]) rem = rem ^ 8'h89;
      end
      for (int i = 0; i < 7; i++) begin
         rem = {rem[6:0], 1'b0};
         if (rem[7]) rem = rem ^ 8'h89;
      end
      return rem[6:0];
   endfunction

   function automatic logic [135:0] build_short(input logic [5:0] ix, input logic [31:0] arg,
                                                input logic tb, input logic eb);
      logic [135:0] f = '0;
      f[47] = 1'b0;
      f[46] = tb;
      f[45:40] = ix;
      f[39:8] = arg;
      f[7:1] = crc7_model(f, 47, 8);
      f[0] = eb;
      return f;
   endfunction

   function automatic logic [135:0] build_long(input logic [119:0] b);
      logic [135:0] f = '0;
      f[133:128] = 6'h3F;
      f[127:8] = b;
      f[7:1] = crc7_model(f, 127, 8);
      f[0] = 1'b1;
      return f;
   endfunction

   function automatic logic [119:0] rand120();
      return {$urandom(), $urandom(), $urandom(), 24'($urandom())};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One bit_en strobe after a random gap; cmd_in is scrambled during the gap
   task automatic strobe(input logic b);
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
         bit_en = 1'b0;
         cmd_in = 1'($urandom_range(0, 1));
         start  = noise_start && ($urandom_range(0, 3) == 0);
         long_resp = 1'($urandom_range(0, 1));
         skip_crc  = 1'($urandom_range(0, 1));
         step();
      end
      bit_en = 1'b1;
      cmd_in = b;
      step();
      bit_en = 1'b0;
      cmd_in = 1'b1;
      start  = 1'b0;
   endtask

   task automatic arm(input logic lng, input logic skp);
      done_cnt  = 0;
      long_resp = lng;
      skip_crc  = skp;
      start     = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
   endtask

   task automatic send_frame(input logic [135:0] f, input logic lng, input logic skp,
                             input int pre_idle);
      arm(lng, skp);
      repeat (pre_idle) strobe(1'b1);
      for (int i = (lng ? 135 : 47); i >= 0; i--) strobe(f[i]);
   endtask

   task automatic check_frame(input string nm, input logic [135:0] f, input logic lng,
                              input logic skp);
      logic [5:0]   e_idx  = lng ? f[133:128] : f[45:40];
      logic [31:0]  e_arg  = lng ? 32'd0 : f[39:8];
      logic [119:0] e_long = lng ? f[127:8] : 120'd0;
      logic [6:0]   calc   = lng ? crc7_model(f, 127, 8) : crc7_model(f, 47, 8);
      logic         e_crc  = !skp && (calc != f[7:1]);
      logic         e_fe   = (lng ? f[134] : f[46]) | ~f[0];
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL %s done/busy got %b/%b want 1/0", nm, done, busy);
      end
      checks++;
      if (resp_index !== e_idx || resp_arg !== e_arg || resp_long !== e_long) begin
         errors++;
         $display("FAIL %s fields got idx=%h arg=%h long=%h want idx=%h arg=%h long=%h",
                  nm, resp_index, resp_arg, resp_long, e_idx, e_arg, e_long);
      end
      checks++;
      if (crc_err !== e_crc || frame_err !== e_fe || timeout !== 1'b0) begin
         errors++;
         $display("FAIL %s status got crc=%b fe=%b to=%b want crc=%b fe=%b to=0",
                  nm, crc_err, frame_err, timeout, e_crc, e_fe);
      end
      step();
      step();
      checks++;
      if (done !== 1'b0 || done_cnt != 1 || resp_index !== e_idx || resp_arg !== e_arg) begin
         errors++;
         $display("FAIL %s hold got done=%b pulses=%0d idx=%h arg=%h want done=0 pulses=1",
                  nm, done, done_cnt, resp_index, resp_arg);
      end
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if ({busy, done, crc_err, frame_err, timeout} !== 5'b0 || resp_index !== 6'd0 ||
          resp_arg !== 32'd0 || resp_long !== 120'd0) begin
         errors++;
         $display("FAIL %s got busy=%b done=%b crc=%b fe=%b to=%b idx=%h arg=%h long=%h want all 0",
                  nm, busy, done, crc_err, frame_err, timeout, resp_index, resp_arg, resp_long);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      check_zero("reset");
   endtask

   task automatic test_r1();
      logic [135:0] f = build_short(6'd17, 32'h0000_0900, 1'b0, 1'b1);
      checks++;
      if (f[7:1] !== 7'b0110011) begin
         errors++; $display("FAIL r1_crc_model got %b want 0110011", f[7:1]);
      end
      send_frame(f, 1'b0, 1'b0, 5);
      check_frame("r1_good", f, 1'b0, 1'b0);
      checks++;
      if (resp_index !== 6'd17 || resp_arg !== 32'h0000_0900 || crc_err !== 1'b0) begin
         errors++; $display("FAIL r1_literal got idx=%0d arg=%h crc=%b want 17 00000900 0",
                            resp_index, resp_arg, crc_err);
      end
      f[19] = ~f[19];
      send_frame(f, 1'b0, 1'b0, 3);
      check_frame("r1_argflip", f, 1'b0, 1'b0);
      checks++;
      if (crc_err !== 1'b1 || resp_arg !== 32'h0000_0100) begin
         errors++; $display("FAIL r1_argflip_literal got crc=%b arg=%h want 1 00000100",
                            crc_err, resp_arg);
      end
   endtask

   task automatic test_framing();
      logic [135:0] f = build_short(6'd17, 32'h0000_0900, 1'b1, 1'b1);
      send_frame(f, 1'b0, 1'b0, 2);
      check_frame("tbit_one", f, 1'b0, 1'b0);
      f = build_short(6'd17, 32'h0000_0900, 1'b0, 1'b0);
      send_frame(f, 1'b0, 1'b0, 0);
      check_frame("end_zero", f, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      arm(1'b0, 1'b0);
      repeat (TIMEOUT - 1) strobe(1'b1);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
         errors++; $display("FAIL timeout_early got done=%b busy=%b to=%b want 0 1 0",
                            done, busy, timeout);
      end
      strobe(1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || timeout !== 1'b1 || resp_arg !== 32'd0 ||
          resp_index !== 6'd0 || crc_err !== 1'b0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL timeout_edge got done=%b busy=%b to=%b arg=%h want 1 0 1 0",
                            done, busy, timeout, resp_arg);
      end
      step();
      checks++;
      if (done !== 1'b0 || timeout !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_hold got done=%b to=%b busy=%b want 0 1 0",
                            done, timeout, busy);
      end
   endtask

   task automatic test_skip_crc();
      logic [135:0] f = build_short(6'h3F, $urandom(), 1'b0, 1'b1);
      f[7:1] = 7'h7F;
      send_frame(f, 1'b0, 1'b1, 4);
      check_frame("r3_skip", f, 1'b0, 1'b1);
      send_frame(f, 1'b0, 1'b0, 4);
      check_frame("r3_noskip", f, 1'b0, 1'b0);
   endtask

   task automatic test_long();
      logic [135:0] f = build_long(rand120());
      send_frame(f, 1'b1, 1'b0, 6);
      check_frame("r2_good", f, 1'b1, 1'b0);
      f = build_long(rand120());
      arm(1'b1, 1'b0);
      for (int i = 135; i >= 128 - 60; i--) strobe(f[i]);
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (3) step();
      check_zero("r2_reset_mid");
      checks++;
      if (done_cnt != 0) begin
         errors++; $display("FAIL r2_reset_pulses got %0d want 0", done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      noise_start = 1'b1;
      for (int n = 0; n < 8; n++) begin
         logic lng = 1'($urandom_range(0, 1));
         logic skp = 1'($urandom_range(0, 1));
         logic [135:0] f = lng ? build_long(rand120())
                               : build_short(6'($urandom()), $urandom(), 1'b0, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            int p = $urandom_range(1, lng ? 134 : 46);
            f[p] = ~f[p];
         end
         send_frame(f, lng, skp, $urandom_range(0, 10));
         check_frame("random", f, lng, skp);
      end
      noise_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
      long_resp = 1'b0; skip_crc = 1'b0;
      test_reset();
      test_r1();
      test_framing();
      test_timeout();
      test_skip_crc();
      test_long();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
